// File: rtl/aurora_cmd_pkg.sv
// aurora_cmd_pkg: shared state encoding and constants for the Aurora command WISHBONE sequencer.
package aurora_cmd_pkg;
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    localparam int          CMD_READ_BIT = 31;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADDEAD;
endpackage

// File: rtl/aurora_wb_timeout.sv
// aurora_wb_timeout: BUS watchdog; reloads on BUS entry and pulses o_expire in the last allowed cycle.
module aurora_wb_timeout
    import aurora_cmd_pkg::*;
#(
    parameter int CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_expire
);
    localparam int W = $clog2(CYCLES);
    logic [W-1:0] r_cnt;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_cnt <= '0;
        else if (i_load) r_cnt <= W'(CYCLES - 1);
        else if (i_run && r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end
    assign o_expire = i_run && r_cnt == '0;
endmodule

// File: rtl/aurora_cmd_wbctl.sv
// aurora_cmd_wbctl: drains Aurora command address/data streams into single WISHBONE classic cycles.
// Define AURORA_WB_TIMEOUT_EN to abort BUS cycles that stall for TIMEOUT_CYCLES.
module aurora_cmd_wbctl
    import aurora_cmd_pkg::*;
#(
    parameter int          ADDR_BITS      = 22,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [31:0]          s_cmd_addr_tdata,
    input  logic                 s_cmd_addr_tvalid,
    output logic                 s_cmd_addr_tready,
    input  logic [31:0]          s_cmd_data_tdata,
    input  logic                 s_cmd_data_tvalid,
    output logic                 s_cmd_data_tready,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [ADDR_BITS-1:0] wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic [3:0]           wb_sel_o,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    output logic [31:0]          m_resp_tdata,
    output logic                 m_resp_tvalid,
    input  logic                 m_resp_tready,
    output logic [7:0]           bus_err_count
);
    state_t               r_state;
    logic                 r_cyc, r_we, r_resp_valid;
    logic [ADDR_BITS-1:0] r_adr;
    logic [31:0]          r_dat, r_resp_data;
    logic [7:0]           r_err_cnt;
    logic                 w_is_rd, w_rd_go, w_wr_go, w_launch, w_in_bus, w_timeout, w_fail, w_unused;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    assign w_unused = ^s_cmd_addr_tdata[31:ADDR_BITS];
    assign w_is_rd  = s_cmd_addr_tdata[CMD_READ_BIT];
    // A read may only launch when the response slot is free, so the bus never waits on the TX path.
    assign w_rd_go  = s_cmd_addr_tvalid && w_is_rd && !r_resp_valid;
    assign w_wr_go  = s_cmd_addr_tvalid && !w_is_rd && s_cmd_data_tvalid;
    assign w_launch = r_state == IDLE && (w_rd_go || w_wr_go);
    assign w_in_bus = r_state == BUS;
    assign w_fail   = wb_err_i || w_timeout;

    assign s_cmd_addr_tready = w_launch;
    assign s_cmd_data_tready = r_state == IDLE && w_wr_go;
    assign wb_cyc_o      = r_cyc;
    assign wb_stb_o      = r_cyc;
    assign wb_we_o       = r_we;
    assign wb_adr_o      = r_adr;
    assign wb_dat_o      = r_dat;
    assign wb_sel_o      = 4'hF;
    assign m_resp_tdata  = r_resp_data;
    assign m_resp_tvalid = r_resp_valid;
    assign bus_err_count = r_err_cnt;

`ifdef AURORA_WB_TIMEOUT_EN
    aurora_wb_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_load  (w_launch),
        .i_run   (w_in_bus),
        .o_expire(w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= IDLE;
            r_cyc        <= 1'b0;
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_err_cnt    <= '0;
        end else begin
            if (r_resp_valid && m_resp_tready) r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: if (w_launch) begin
                    r_state <= BUS;
                    r_cyc   <= 1'b1;
                    r_we    <= !w_is_rd;
                    r_adr   <= s_cmd_addr_tdata[ADDR_BITS-1:0];
                    r_dat   <= s_cmd_data_tdata;
                end
                BUS: if (wb_ack_i || w_fail) begin
                    r_state <= DONE;
                    r_cyc   <= 1'b0;
                    if (w_fail && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                    if (!r_we) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_fail ? ERR_DATA : wb_dat_i;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aurora_cmd_wbctl.sv
// tb_aurora_cmd_wbctl: directed checks of launch, response, backpressure, error, timeout and reset behaviour.
module tb_aurora_cmd_wbctl;
    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_cmd_addr_tdata, s_cmd_data_tdata, wb_dat_i, wb_dat_o, m_resp_tdata;
    logic        s_cmd_addr_tvalid, s_cmd_addr_tready, s_cmd_data_tvalid, s_cmd_data_tready;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i, m_resp_tvalid, m_resp_tready;
    logic [21:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [7:0]  bus_err_count;
    int          n_chk = 0;
    int          n_err = 0;

    aurora_cmd_wbctl #(.ADDR_BITS(22), .ERR_DATA(32'hDEADDEAD), .TIMEOUT_CYCLES(16)) dut (
        .aclk(aclk), .areset(areset),
        .s_cmd_addr_tdata(s_cmd_addr_tdata), .s_cmd_addr_tvalid(s_cmd_addr_tvalid), .s_cmd_addr_tready(s_cmd_addr_tready),
        .s_cmd_data_tdata(s_cmd_data_tdata), .s_cmd_data_tvalid(s_cmd_data_tvalid), .s_cmd_data_tready(s_cmd_data_tready),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .m_resp_tdata(m_resp_tdata), .m_resp_tvalid(m_resp_tvalid), .m_resp_tready(m_resp_tready),
        .bus_err_count(bus_err_count)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
    endtask

    initial begin
        areset = 1'b1;
        s_cmd_addr_tdata = '0; s_cmd_addr_tvalid = 1'b0;
        s_cmd_data_tdata = '0; s_cmd_data_tvalid = 1'b0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; m_resp_tready = 1'b0;
        tick(); tick();
        #1;
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_rvalid", m_resp_tvalid, 0);
        chk("rst_rdata", m_resp_tdata, 0);
        chk("rst_errcnt", bus_err_count, 0);
        chk("sel", wb_sel_o, 4'hF);
        tick();
        areset = 1'b0;
        tick();

        // write with ack two cycles after stb
        s_cmd_addr_tdata = 32'h0000_0010; s_cmd_addr_tvalid = 1'b1;
        s_cmd_data_tdata = 32'h1234_5678; s_cmd_data_tvalid = 1'b1;
        #1;
        chk("wr_addr_rdy", s_cmd_addr_tready, 1);
        chk("wr_data_rdy", s_cmd_data_tready, 1);
        tick();
        s_cmd_addr_tvalid = 1'b0; s_cmd_data_tvalid = 1'b0;
        #1;
        chk("wr_cyc", wb_cyc_o, 1);
        chk("wr_stb", wb_stb_o, 1);
        chk("wr_we", wb_we_o, 1);
        chk("wr_adr", wb_adr_o, 32'h10);
        chk("wr_dat", wb_dat_o, 32'h1234_5678);
        tick();
        chk("wr_cyc_hold", wb_cyc_o, 1);
        chk("wr_adr_hold", wb_adr_o, 32'h10);
        tick();
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        chk("wr_cyc_end", wb_cyc_o, 0);
        chk("wr_no_resp", m_resp_tvalid, 0);

        // read offered during DONE must wait for IDLE
        s_cmd_addr_tdata = 32'h8000_0020; s_cmd_addr_tvalid = 1'b1;
        #1;
        chk("done_block", s_cmd_addr_tready, 0);
        tick();
        #1;
        chk("rd_addr_rdy", s_cmd_addr_tready, 1);
        chk("rd_data_rdy", s_cmd_data_tready, 0);
        tick();
        s_cmd_addr_tvalid = 1'b0;
        chk("rd_cyc", wb_cyc_o, 1);
        chk("rd_we", wb_we_o, 0);
        chk("rd_adr", wb_adr_o, 32'h20);
        wb_dat_i = 32'hCAFE_BABE; wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        chk("rd_cyc_end", wb_cyc_o, 0);
        chk("rd_rvalid", m_resp_tvalid, 1);
        chk("rd_rdata", m_resp_tdata, 32'hCAFE_BABE);
        tick();
        chk("rd_rvalid_hold", m_resp_tvalid, 1);
        chk("rd_rdata_hold", m_resp_tdata, 32'hCAFE_BABE);
        m_resp_tready = 1'b1;
        tick();
        m_resp_tready = 1'b0;
        chk("rd_rvalid_clr", m_resp_tvalid, 0);

        // backpressure: second read held off until first response is accepted
        s_cmd_addr_tdata = 32'h8000_0030; s_cmd_addr_tvalid = 1'b1;
        tick();
        chk("bp_a_cyc", wb_cyc_o, 1);
        wb_dat_i = 32'h1111_1111; wb_ack_i = 1'b1;
        s_cmd_addr_tdata = 32'h8000_0040;
        tick();
        wb_ack_i = 1'b0;
        chk("bp_a_rdata", m_resp_tdata, 32'h1111_1111);
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("bp_b_rdy", s_cmd_addr_tready, 0);
            chk("bp_b_cyc", wb_cyc_o, 0);
            tick();
        end
        chk("bp_a_hold", m_resp_tvalid, 1);
        m_resp_tready = 1'b1;
        #1;
        chk("bp_b_rdy_acc", s_cmd_addr_tready, 0);
        tick();
        m_resp_tready = 1'b0;
        #1;
        chk("bp_b_rdy_free", s_cmd_addr_tready, 1);
        tick();
        s_cmd_addr_tvalid = 1'b0;
        chk("bp_b_cyc_go", wb_cyc_o, 1);
        chk("bp_b_adr", wb_adr_o, 32'h40);
        wb_dat_i = 32'h2222_2222; wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        chk("bp_b_rdata", m_resp_tdata, 32'h2222_2222);
        m_resp_tready = 1'b1;
        tick();
        m_resp_tready = 1'b0;

        // write address without data never pops
        s_cmd_addr_tdata = 32'h0000_0050; s_cmd_addr_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("md_cyc", wb_cyc_o, 0);
            chk("md_addr_rdy", s_cmd_addr_tready, 0);
            chk("md_data_rdy", s_cmd_data_tready, 0);
            tick();
        end
        s_cmd_data_tdata = 32'hA5A5_A5A5; s_cmd_data_tvalid = 1'b1;
        #1;
        chk("md_addr_rdy_go", s_cmd_addr_tready, 1);
        chk("md_data_rdy_go", s_cmd_data_tready, 1);
        tick();
        s_cmd_addr_tvalid = 1'b0; s_cmd_data_tvalid = 1'b0;
        chk("md_cyc_go", wb_cyc_o, 1);
        chk("md_adr", wb_adr_o, 32'h50);
        chk("md_dat", wb_dat_o, 32'hA5A5_A5A5);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        chk("md_no_resp", m_resp_tvalid, 0);
        tick();

        // termination inputs are ignored outside BUS
        wb_ack_i = 1'b1; wb_err_i = 1'b1;
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        chk("idle_err_ign", bus_err_count, 0);
        chk("idle_cyc", wb_cyc_o, 0);

        // err and ack together: err wins
        s_cmd_addr_tdata = 32'h8000_0060; s_cmd_addr_tvalid = 1'b1;
        tick();
        s_cmd_addr_tvalid = 1'b0;
        wb_dat_i = 32'h5555_5555; wb_ack_i = 1'b1; wb_err_i = 1'b1;
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        chk("err_rvalid", m_resp_tvalid, 1);
        chk("err_rdata", m_resp_tdata, 32'hDEAD_DEAD);
        chk("err_cnt1", bus_err_count, 1);
        m_resp_tready = 1'b1;
        tick();
        m_resp_tready = 1'b0;

        // write err counts but produces no response
        s_cmd_addr_tdata = 32'h0000_0080; s_cmd_addr_tvalid = 1'b1;
        s_cmd_data_tdata = 32'h0000_0001; s_cmd_data_tvalid = 1'b1;
        tick();
        s_cmd_addr_tvalid = 1'b0; s_cmd_data_tvalid = 1'b0;
        wb_err_i = 1'b1;
        tick();
        wb_err_i = 1'b0;
        chk("werr_no_resp", m_resp_tvalid, 0);
        chk("werr_cnt2", bus_err_count, 2);
        tick();

        // stalled read
        s_cmd_addr_tdata = 32'h8000_0070; s_cmd_addr_tvalid = 1'b1;
        tick();
        s_cmd_addr_tvalid = 1'b0;
`ifdef AURORA_WB_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            chk("to_cyc_high", wb_cyc_o, 1);
            tick();
        end
        chk("to_cyc_drop", wb_cyc_o, 0);
        chk("to_rvalid", m_resp_tvalid, 1);
        chk("to_rdata", m_resp_tdata, 32'hDEAD_DEAD);
        chk("to_cnt3", bus_err_count, 3);
`else
        for (int i = 0; i < 40; i++) begin
            chk("nto_cyc_high", wb_cyc_o, 1);
            tick();
        end
        wb_dat_i = 32'h0BAD_F00D; wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        chk("nto_rdata", m_resp_tdata, 32'h0BAD_F00D);
        chk("nto_cnt2", bus_err_count, 2);
`endif
        m_resp_tready = 1'b1;
        tick();
        m_resp_tready = 1'b0;
        tick();

        // asynchronous reset in the middle of a read
        s_cmd_addr_tdata = 32'h8000_0090; s_cmd_addr_tvalid = 1'b1;
        tick();
        s_cmd_addr_tvalid = 1'b0;
        chk("ar_cyc_pre", wb_cyc_o, 1);
        #2 areset = 1'b1;
        #1;
        chk("ar_cyc", wb_cyc_o, 0);
        chk("ar_stb", wb_stb_o, 0);
        chk("ar_rvalid", m_resp_tvalid, 0);
        chk("ar_cnt", bus_err_count, 0);
        tick();
        areset = 1'b0;
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        tick();
        chk("ar_no_resp", m_resp_tvalid, 0);
        chk("ar_idle_cyc", wb_cyc_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
